dqpsk_mod_param: RTL and testbench
==================================

// Module: dqpsk_mod_param
// PURPOSE
//   Parametrised DQPSK / pi/4-DQPSK baseband+IF modulator, self-contained (no FIR/NCO/mult cores).
//   Serial bits in via valid/ready; Gray dibit -> differential phase index (8 x 45 deg).
//   Symbols held for SPS samples, then mixed onto an fs/4 quadrature carrier.
//   Sits between the bit source and the DAC interface.
//   Adds three things: runtime mode select, input back-pressure, and underrun signalling.
// PARAMETERS
//   SPS  8      samples (clk cycles) per symbol; legal range SPS>=4
//   OW   16     width of i_out/q_out/dout, two's complement
//   AMP  32767  on-axis amplitude; AMP <= 2^(OW-1)-1. Diagonal amplitude is DIAG = round(AMP*0.70711) = 23170.
// PORTS
//   clk        in   1   system clock (one clock domain)
//   reset_n    in   1   asynchronous reset, active low
//   mode       in   1   0 = DQPSK, 1 = pi/4-DQPSK; sampled only at symbol load
//   din        in   1   serial data bit; first bit of a pair is the dibit MSB
//   din_valid  in   1   din valid
//   din_ready  out  1   block can accept a bit this cycle
//   i_out      out  OW  baseband in-phase (held for the symbol)
//   q_out      out  OW  baseband quadrature
//   dout       out  OW  modulated IF sample
//   sym_strobe out  1   1-cycle pulse: a symbol was loaded
//   underrun   out  1   1-cycle pulse: symbol boundary reached with no dibit pending
// BEHAVIOUR
//   Reset (async, reset_n=0)
//     - All registers clear: cnt=0, k=0, phase p=0, half=0, pend_full=0.
//     - i_out/q_out/dout=0; sym_strobe=0; underrun=0.
//     - Handshakes are ignored while reset_n=0. Reset mid-symbol discards the partial pair and the pending dibit.
//   Input
//     - Handshake: transfer when din_valid & din_ready.
//     - din_ready = ~pend_full (registered flag).
//     - 1st accepted bit goes to the MSB latch (half=1).
//     - 2nd accepted bit completes the dibit: pend_full=1, half=0.
//     - din_ready falls on the cycle after pend_full sets.
//     - din_ready rises on the cycle after the dibit is consumed.
//   Symbol timer
//     - cnt counts 0..SPS-1 and wraps.
//     - tick = (cnt==SPS-1).
//     - Load uses the registered pend_full only; there is no bypass.
//     - A pair completing on a tick cycle is consumed at the next tick.
//   On tick with pend_full=1
//     - p <= (p + inc) mod 8; pend_full <= 0; sym_strobe=1 next cycle.
//     - DQPSK   (mode=0): 00->+0, 01->+2, 11->+4, 10->+6.
//     - pi/4    (mode=1): 00->+1, 01->+3, 11->+5, 10->+7.
//   On tick with pend_full=0
//     - underrun=1 next cycle; p is held.
//     - i_out/q_out = 0 for the whole next symbol (silent symbol).
//   Mapping (registered; i/q valid the cycle after tick)
//     - p=0:( AMP,0)      p=1:( DIAG, DIAG)  p=2:(0, AMP)     p=3:(-DIAG, DIAG)
//     - p=4:(-AMP,0)      p=5:(-DIAG,-DIAG)  p=6:(0,-AMP)     p=7:( DIAG,-DIAG)
//   Carrier
//     - k is a free-running 2-bit counter.
//     - dout (registered, 1 cycle after i/q) = I*cos(k*90) - Q*sin(k*90):
//       k=0:I, k=1:-Q, k=2:-I, k=3:Q.
//     - Because AMP <= 2^(OW-1)-1, negation never overflows; no saturation logic.
//   Latency
//     - tick cycle t -> i_out/q_out at t+1 -> dout at t+2.
//     - Before the first symbol load, outputs stay 0.
// TESTING
//   1. Hold reset_n=0 for 5 cycles with din_valid=1 -> all outputs 0.
//      Release, no data -> underrun pulses at cycles 8,16,24 (SPS=8); i/q/dout stay 0.
//   2. mode=0, bits 00 01 11 10 streamed -> p=0,2,6,4 -> (i,q) = (32767,0), (0,32767), (0,-32767), (-32767,0).
//   3. mode=1 from reset, bits 00 00 00 -> p=1,2,3 -> (i,q) = (23170,23170), (0,32767), (-23170,23170).
//   4. Hold p=0 (i=32767, q=0) -> dout repeats 32767, 0, -32767, 0 in step with k; i_out constant for 8 cycles.
//   5. Starve after 2 symbols -> underrun=1 once, i/q=0 for 8 cycles.
//      Then feed 01 in mode=0 -> phase continues from the held p (p+2), sym_strobe=1.
//   6. Assert reset_n=0 mid-symbol with one bit latched and a pending dibit -> all clear.
//      After release, first dibit 00 in mode=0 gives i=32767, q=0.

Source files
------------

// File: rtl/dqpsk_mod_param.sv
// DQPSK / pi/4-DQPSK modulator: serial bits -> Gray dibit -> differential 8-phase
// symbol held for SPS samples -> mixed onto an fs/4 quadrature IF carrier.
module dqpsk_mod_param #(
  parameter int unsigned SPS = 8,
  parameter int unsigned OW  = 16,
  parameter int unsigned AMP = 32767
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mode,
  input  logic                 din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic signed [OW-1:0] i_out,
  output logic signed [OW-1:0] q_out,
  output logic signed [OW-1:0] dout,
  output logic                 sym_strobe,
  output logic                 underrun
);

  localparam int unsigned     CW       = (SPS > 1) ? $clog2(SPS) : 1;
  localparam longint unsigned DIAG     = (64'(AMP) * 64'd70711 + 64'd50000) / 64'd100000;
  localparam logic signed [OW-1:0] AMP_V  = OW'(AMP);
  localparam logic signed [OW-1:0] DIAG_V = OW'(DIAG);
  localparam logic [CW-1:0]   CNT_LAST = CW'(SPS - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    k;
  logic [2:0]    p;
  logic          half;
  logic          msb;
  logic          pend_full;
  logic [1:0]    dibit;

  logic                 tick_c;
  logic                 accept_c;
  logic [2:0]           inc_c;
  logic [2:0]           p_next_c;
  logic signed [OW-1:0] i_map_c;
  logic signed [OW-1:0] q_map_c;
  logic signed [OW-1:0] if_c;

  assign tick_c   = (cnt == CNT_LAST);
  assign accept_c = din_valid & ~pend_full;

  // Gray dibit -> phase step in 45 degree units; pi/4 mode adds one odd step
  always_comb begin
    inc_c = 3'd0;
    unique case (dibit)
      2'b00:   inc_c = 3'd0;
      2'b01:   inc_c = 3'd2;
      2'b11:   inc_c = 3'd4;
      default: inc_c = 3'd6;
    endcase
    inc_c    = inc_c | {2'b00, mode};
    p_next_c = p + inc_c;
  end

  // Constellation lookup for the phase about to be loaded
  always_comb begin
    i_map_c = '0;
    q_map_c = '0;
    unique case (p_next_c)
      3'd0: begin i_map_c =  AMP_V;  q_map_c = '0;      end
      3'd1: begin i_map_c =  DIAG_V; q_map_c =  DIAG_V; end
      3'd2: begin i_map_c = '0;      q_map_c =  AMP_V;  end
      3'd3: begin i_map_c = -DIAG_V; q_map_c =  DIAG_V; end
      3'd4: begin i_map_c = -AMP_V;  q_map_c = '0;      end
      3'd5: begin i_map_c = -DIAG_V; q_map_c = -DIAG_V; end
      3'd6: begin i_map_c = '0;      q_map_c = -AMP_V;  end
      default: begin i_map_c = DIAG_V; q_map_c = -DIAG_V; end
    endcase
  end

  // fs/4 mixer: I*cos(k*90) - Q*sin(k*90) reduces to a 4-way select with negation
  always_comb begin
    if_c = '0;
    unique case (k)
      2'd0:    if_c =  i_out;
      2'd1:    if_c = -q_out;
      2'd2:    if_c = -i_out;
      default: if_c =  q_out;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      k          <= '0;
      p          <= '0;
      half       <= 1'b0;
      msb        <= 1'b0;
      pend_full  <= 1'b0;
      din_ready  <= 1'b1;
      dibit      <= '0;
      i_out      <= '0;
      q_out      <= '0;
      dout       <= '0;
      sym_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      k          <= k + 2'd1;
      cnt        <= tick_c ? '0 : cnt + CW'(1);
      dout       <= if_c;
      sym_strobe <= tick_c & pend_full;
      underrun   <= tick_c & ~pend_full;
      // Symbol boundary: load the registered pending dibit or emit a silent symbol
      if (tick_c) begin
        if (pend_full) begin
          p         <= p_next_c;
          i_out     <= i_map_c;
          q_out     <= q_map_c;
          pend_full <= 1'b0;
          din_ready <= 1'b1;
        end else begin
          i_out <= '0;
          q_out <= '0;
        end
      end
      // Bit assembly; ready is low while a dibit is pending, so no overlap with the load
      if (accept_c) begin
        if (!half) begin
          msb  <= din;
          half <= 1'b1;
        end else begin
          dibit     <= {msb, din};
          pend_full <= 1'b1;
          din_ready <= 1'b0;
          half      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dqpsk_mod_param.sv
// Bench for dqpsk_mod_param: directed vector table, corner sequences and a
// randomized run against a trigonometric reference model.
module tb_dqpsk_mod_param;

  localparam int unsigned SPS = 8;
  localparam int unsigned OW  = 16;
  localparam int          AMP = 32767;
  localparam real         PI  = 3.14159265358979323846;

  logic                 clk;
  logic                 reset_n;
  logic                 mode;
  logic                 din;
  logic                 din_valid;
  logic                 din_ready;
  logic signed [OW-1:0] i_out;
  logic signed [OW-1:0] q_out;
  logic signed [OW-1:0] dout;
  logic                 sym_strobe;
  logic                 underrun;

  dqpsk_mod_param #(.SPS(SPS), .OW(OW), .AMP(AMP)) dut (
    .clk(clk), .reset_n(reset_n), .mode(mode), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .i_out(i_out), .q_out(q_out), .dout(dout),
    .sym_strobe(sym_strobe), .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  int       m_cnt, m_p, m_k, m_i, m_q, m_dout;
  bit       m_half, m_msb, m_pend, m_strobe, m_under;
  bit [1:0] m_dib;
  bit       bq[$];
  bit       gap_en;
  bit       rand_mode;

  typedef struct { bit rst; bit md; bit [1:0] dib; int ei; int eq; } vec_t;
  vec_t tbl[7];

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    return -$rtoi(0.5 - x);
  endfunction

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic int phase_inc(bit [1:0] d, bit md);
    int s;
    case (d)
      2'b00:   s = 0;
      2'b01:   s = 2;
      2'b11:   s = 4;
      default: s = 6;
    endcase
    return s + (md ? 1 : 0);
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_p = 0; m_k = 0; m_i = 0; m_q = 0; m_dout = 0;
    m_half = 0; m_msb = 0; m_pend = 0; m_strobe = 0; m_under = 0; m_dib = 2'b00;
  endtask

  // One clock edge of the modulator described as phase arithmetic and cos/sin
  task automatic model_edge();
    bit rdy;
    bit tick;
    int nd;
    rdy  = !m_pend;
    tick = (m_cnt == int'(SPS) - 1);
    nd   = rnd(real'(m_i) * $cos(PI * real'(m_k) / 2.0) - real'(m_q) * $sin(PI * real'(m_k) / 2.0));
    m_strobe = 0;
    m_under  = 0;
    if (tick) begin
      if (m_pend) begin
        m_p = (m_p + phase_inc(m_dib, mode)) % 8;
        m_i = rnd(real'(AMP) * $cos(PI * real'(m_p) / 4.0));
        m_q = rnd(real'(AMP) * $sin(PI * real'(m_p) / 4.0));
        m_strobe = 1;
        m_pend   = 0;
      end else begin
        m_i = 0;
        m_q = 0;
        m_under = 1;
      end
    end
    if (din_valid && rdy) begin
      if (!m_half) begin
        m_msb  = din;
        m_half = 1;
      end else begin
        m_dib  = {m_msb, din};
        m_pend = 1;
        m_half = 0;
      end
      if (bq.size() > 0) void'(bq.pop_front());
    end
    m_dout = nd;
    m_cnt  = (m_cnt + 1) % int'(SPS);
    m_k    = (m_k + 1) % 4;
  endtask

  task automatic compare_all();
    check("i_out", int'(i_out), m_i);
    check("q_out", int'(q_out), m_q);
    check("dout", int'(dout), m_dout);
    check("sym_strobe", int'(sym_strobe), int'(m_strobe));
    check("underrun", int'(underrun), int'(m_under));
    check("din_ready", int'(din_ready), m_pend ? 0 : 1);
  endtask

  task automatic drive();
    if (!reset_n) begin
      din_valid = 1'b1;
      din       = 1'b1;
    end else begin
      din_valid = (bq.size() > 0) && (!gap_en || $urandom_range(0, 3) != 0);
      din       = (bq.size() > 0) ? bq[0] : 1'b0;
      if (rand_mode) mode = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    compare_all();
    drive();
  endtask

  task automatic push_dibit(bit [1:0] d);
    bq.push_back(d[1]);
    bq.push_back(d[0]);
    drive();
  endtask

  task automatic wait_strobe(string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!sym_strobe && n < 3 * int'(SPS));
    check({name, "_strobe"}, int'(sym_strobe), 1);
  endtask

  // Asynchronous reset asserted mid-cycle, held for a few edges, released mid-cycle
  task automatic do_reset(int cycles);
    reset_n = 1'b0;
    bq.delete();
    model_reset();
    drive();
    #1;
    check("rst_i", int'(i_out), 0);
    check("rst_q", int'(q_out), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_strobe", int'(sym_strobe), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_ready", int'(din_ready), 1);
    repeat (cycles) step();
    reset_n   = 1'b1;
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  initial begin
    int d[8];
    int cnt_u;
    reset_n = 1'b1; mode = 1'b0; din = 1'b0; din_valid = 1'b0;
    gap_en = 0; rand_mode = 0;
    model_reset();
    #2;

    // idle after reset: underrun every SPS cycles, outputs silent
    do_reset(5);
    for (int n = 1; n <= 24; n++) begin
      step();
      check("idle_underrun", int'(underrun), (n % 8 == 0) ? 1 : 0);
      check("idle_dout", int'(dout), 0);
    end

    // directed symbol table
    tbl[0] = '{rst:1, md:0, dib:2'b00, ei: 32767, eq: 0};
    tbl[1] = '{rst:0, md:0, dib:2'b01, ei: 0,     eq: 32767};
    tbl[2] = '{rst:0, md:0, dib:2'b11, ei: 0,     eq: -32767};
    tbl[3] = '{rst:0, md:0, dib:2'b10, ei: -32767, eq: 0};
    tbl[4] = '{rst:1, md:1, dib:2'b00, ei: 23170, eq: 23170};
    tbl[5] = '{rst:0, md:1, dib:2'b00, ei: 0,     eq: 32767};
    tbl[6] = '{rst:0, md:1, dib:2'b00, ei: -23170, eq: 23170};
    for (int v = 0; v < 7; v++) begin
      if (tbl[v].rst) do_reset(3);
      mode = tbl[v].md;
      push_dibit(tbl[v].dib);
      wait_strobe("tbl");
      check("tbl_i", int'(i_out), tbl[v].ei);
      check("tbl_q", int'(q_out), tbl[v].eq);
    end

    // held phase 0: i constant, dout cycles through +A, 0, -A, 0
    do_reset(3);
    mode = 1'b0;
    for (int j = 0; j < 4; j++) push_dibit(2'b00);
    wait_strobe("hold");
    for (int j = 0; j < 8; j++) begin
      step();
      check("hold_i", int'(i_out), 32767);
      d[j] = int'(dout);
    end
    for (int j = 0; j < 6; j++) begin
      check("hold_dout_neg", d[j + 2], -d[j]);
      check("hold_dout_mag", iabs(d[j]) + iabs(d[j + 1]), 32767);
    end

    // starvation: one underrun, silent symbol, then phase continues from held p
    do_reset(3);
    mode = 1'b0;
    push_dibit(2'b01);
    push_dibit(2'b00);
    wait_strobe("starve1");
    wait_strobe("starve2");
    check("starve_pre_q", int'(q_out), 32767);
    begin
      int n = 0;
      do begin
        step();
        n++;
      end while (!underrun && n < 3 * int'(SPS));
    end
    check("starve_underrun", int'(underrun), 1);
    check("starve_i0", int'(i_out), 0);
    push_dibit(2'b01);
    cnt_u = 0;
    for (int j = 1; j < int'(SPS); j++) begin
      step();
      check("silent_i", int'(i_out), 0);
      check("silent_q", int'(q_out), 0);
      cnt_u += int'(underrun);
    end
    wait_strobe("resume");
    check("resume_extra_underrun", cnt_u, 0);
    check("resume_i", int'(i_out), -32767);
    check("resume_q", int'(q_out), 0);

    // reset with a pending dibit and a waiting bit
    do_reset(3);
    mode = 1'b0;
    push_dibit(2'b11);
    bq.push_back(1'b1);
    drive();
    repeat (4) step();
    check("pend_ready_low", int'(din_ready), 0);
    do_reset(2);
    push_dibit(2'b00);
    wait_strobe("after_rst_pend");
    check("after_rst_pend_i", int'(i_out), 32767);
    check("after_rst_pend_q", int'(q_out), 0);

    // reset with a half-assembled pair: stale MSB must not pair with new bits
    do_reset(3);
    bq.push_back(1'b1);
    drive();
    repeat (2) step();
    do_reset(2);
    push_dibit(2'b00);
    wait_strobe("after_rst_half");
    check("after_rst_half_i", int'(i_out), 32767);
    check("after_rst_half_q", int'(q_out), 0);

    // randomized traffic: bit gaps, per-cycle mode changes, periodic starvation
    do_reset(3);
    gap_en = 1;
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      if (bq.size() < 3 && (c % 400) < 350 && $urandom_range(0, 9) != 0)
        bq.push_back(1'($urandom_range(0, 1)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
